// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the tiny-SAR ADC sequencer.
//   - sar_state_e : sequencer FSM encoding (IDLE=0, SAMPLE=1, CONVERT=2, DONE=3)
//   - SAR_*_DEF   : default resolution/timing, shared with the clock generator
//                   and the result FIFO
//   - sar_max     : helper for sizing counters from two timing parameters
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_e;

  localparam int SAR_N_BITS_DEF         = 8;
  localparam int SAR_SAMPLE_CYCLES_DEF  = 2;
  localparam int SAR_CYCLES_PER_BIT_DEF = 1;

  function automatic int sar_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_phase_counter.sv
// sar_phase_counter: loadable down-counter with terminal-count flag.
// Times both the sample window and each bit trial. Loading N-1 makes tc_o
// assert on the N-th cycle after the load. The counter parks at zero rather
// than wrapping.
// Ports:
//   clk_i      : clock (rising edge)
//   rst_i      : synchronous active-high reset
//   load_i     : load load_val_i this cycle (takes priority over counting)
//   load_val_i : value to load
//   tc_o       : count has reached zero
module sar_phase_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)               cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation sequencer for the tiny-SAR ADC.
// Runs the S/H window, walks the DAC trial code MSB->LSB from the comparator
// decision, and publishes the result with a one-cycle valid strobe.
// All outputs are registered: the comb block computes next-cycle values.
// Ports:
//   clk_in     : SAR operation clock
//   rst        : synchronous active-high reset
//   start      : conversion request (level; held high = continuous)
//   cmp_in     : comparator, 1 = Vin >= Vdac (keep trial bit)
//   sample_en  : S/H switch enable
//   dac_code   : trial code to the capacitive DAC
//   data_out   : last completed conversion
//   data_valid : one-cycle strobe with a new data_out
//   busy       : high in SAMPLE, CONVERT, DONE
//   overrun    : one-cycle pulse, start seen during SAMPLE/CONVERT
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int N_BITS         = SAR_N_BITS_DEF,
  parameter int SAMPLE_CYCLES  = SAR_SAMPLE_CYCLES_DEF,
  parameter int CYCLES_PER_BIT = SAR_CYCLES_PER_BIT_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic              cmp_in,
  output logic              sample_en,
  output logic [N_BITS-1:0] dac_code,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = $clog2(sar_max(SAMPLE_CYCLES, CYCLES_PER_BIT) + 1);
  localparam int IDX_W = $clog2(N_BITS);
  localparam logic [CNT_W-1:0]  SAMPLE_LD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BIT_LD    = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(N_BITS - 1);
  localparam logic [N_BITS-1:0] ONE       = N_BITS'(1);
  localparam logic [N_BITS-1:0] TOP_BIT   = ONE << (N_BITS - 1);

  sar_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_BITS-1:0] dac_q, dac_d, dout_q, dout_d;
  logic              se_q, se_d, vld_q, vld_d, busy_q, busy_d, ovr_q, ovr_d;
  logic              cnt_load, cnt_tc;
  logic [CNT_W-1:0]  cnt_val;
  logic [N_BITS-1:0] bit_cur, bit_nxt, kept;

  sar_phase_counter #(.W(CNT_W)) u_phase (
    .clk_i      (clk_in),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc)
  );

  // Trial bit under test, the next one down, and the code after this decision.
  assign bit_cur = ONE << idx_q;
  assign bit_nxt = ONE << (idx_q - 1'b1);
  assign kept    = cmp_in ? dac_q : (dac_q & ~bit_cur);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dac_d    = dac_q;
    dout_d   = dout_q;
    se_d     = 1'b0;
    vld_d    = 1'b0;
    busy_d   = 1'b0;
    ovr_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = SAMPLE_LD;
    unique case (state_q)
      ST_IDLE: begin
        dac_d = '0;
        if (start) begin
          state_d  = ST_SAMPLE;
          se_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end
      ST_SAMPLE: begin
        busy_d = 1'b1;
        ovr_d  = start;
        if (cnt_tc) begin
          state_d  = ST_CONVERT;
          idx_d    = IDX_TOP;
          dac_d    = TOP_BIT;
          cnt_load = 1'b1;
          cnt_val  = BIT_LD;
        end else begin
          se_d = 1'b1;
        end
      end
      ST_CONVERT: begin
        busy_d = 1'b1;
        ovr_d  = start;
        // Comparator only matters on the last cycle of a trial.
        if (cnt_tc) begin
          if (idx_q == '0) begin
            state_d = ST_DONE;
            dac_d   = kept;
            dout_d  = kept;
            vld_d   = 1'b1;
          end else begin
            idx_d    = idx_q - 1'b1;
            dac_d    = kept | bit_nxt;
            cnt_load = 1'b1;
            cnt_val  = BIT_LD;
          end
        end
      end
      ST_DONE: begin
        dac_d = '0;
        if (start) begin
          state_d  = ST_SAMPLE;
          se_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dac_q   <= '0;
      dout_q  <= '0;
      se_q    <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dac_q   <= dac_d;
      dout_q  <= dout_d;
      se_q    <= se_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_en  = se_q;
  assign dac_code   = dac_q;
  assign data_out   = dout_q;
  assign data_valid = vld_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// tb_sar_ctrl: directed + randomized bench for sar_ctrl. Instance 0 uses the
// defaults (8b, 2 sample, 1 cycle/bit); instance 1 uses 4b, 3 sample,
// 2 cycles/bit. The comparator model answers (Vin >= dac_code) on the last
// cycle of each trial and random noise elsewhere.
module tb_sar_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, cmp0 = 1'b0, start1 = 1'b0, cmp1 = 1'b0;
  logic       se0, dv0, busy0, ovr0, se1, dv1, busy1, ovr1;
  logic [7:0] dac0, do0;
  logic [3:0] dac1, do1;

  sar_ctrl u0 (
    .clk_in(clk), .rst(rst), .start(start0), .cmp_in(cmp0),
    .sample_en(se0), .dac_code(dac0), .data_out(do0),
    .data_valid(dv0), .busy(busy0), .overrun(ovr0)
  );

  sar_ctrl #(.N_BITS(4), .SAMPLE_CYCLES(3), .CYCLES_PER_BIT(2)) u1 (
    .clk_in(clk), .rst(rst), .start(start1), .cmp_in(cmp1),
    .sample_en(se1), .dac_code(dac1), .data_out(do1),
    .data_valid(dv1), .busy(busy1), .overrun(ovr1)
  );

  int tests = 0;
  int fails = 0;
  int prev_res [2];

  function automatic int nb(input int s);  return s ? 4 : 8; endfunction
  function automatic int scy(input int s); return s ? 3 : 2; endfunction
  function automatic int cpb(input int s); return s ? 2 : 1; endfunction

  function automatic logic [31:0] o_se(input int s);   return s ? 32'(se1)   : 32'(se0);   endfunction
  function automatic logic [31:0] o_dac(input int s);  return s ? 32'(dac1)  : 32'(dac0);  endfunction
  function automatic logic [31:0] o_do(input int s);   return s ? 32'(do1)   : 32'(do0);   endfunction
  function automatic logic [31:0] o_dv(input int s);   return s ? 32'(dv1)   : 32'(dv0);   endfunction
  function automatic logic [31:0] o_busy(input int s); return s ? 32'(busy1) : 32'(busy0); endfunction
  function automatic logic [31:0] o_ovr(input int s);  return s ? 32'(ovr1)  : 32'(ovr0);  endfunction

  task automatic set_start(input int s, input logic v);
    if (s != 0) start1 = v; else start0 = v;
  endtask

  task automatic set_cmp(input int s, input logic v);
    if (s != 0) cmp1 = v; else cmp0 = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Binary search reference: DAC code presented during trial t for input vin.
  function automatic int exp_dac(input int vin, input int n, input int t);
    int code = 0;
    for (int k = 0; k <= t; k++) begin
      int trial = code | (1 << (n - 1 - k));
      if (k == t) return trial;
      if (vin >= trial) code = trial;
    end
    return code;
  endfunction

  task automatic chk_zero(input int s, input string tag);
    chk({tag, "_se"},   o_se(s),   0);
    chk({tag, "_dac"},  o_dac(s),  0);
    chk({tag, "_do"},   o_do(s),   0);
    chk({tag, "_dv"},   o_dv(s),   0);
    chk({tag, "_busy"}, o_busy(s), 0);
    chk({tag, "_ovr"},  o_ovr(s),  0);
  endtask

  task automatic idle(input int s, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      set_start(s, 1'b0);
      set_cmp(s, 1'($urandom));
      @(posedge clk); #1;
      chk("idle_busy", o_busy(s), 0);
      chk("idle_se",   o_se(s),   0);
      chk("idle_dac",  o_dac(s),  0);
      chk("idle_dv",   o_dv(s),   0);
      chk("idle_ovr",  o_ovr(s),  0);
    end
  endtask

  // One conversion. hold keeps start high throughout (continuous mode);
  // ovr_c re-raises start for one cycle; rst_c asserts reset at that cycle.
  task automatic conv(input int s, input int vin_in, input bit hold,
                      input int ovr_c, input int rst_c);
    int   n, sc, cp, cv_end, lat, vin;
    logic st_prev, sv, correct, last;
    n = nb(s); sc = scy(s); cp = cpb(s);
    cv_end = sc + n * cp;
    lat = cv_end + 1;
    vin = vin_in & ((1 << n) - 1);
    set_start(s, 1'b1);
    @(posedge clk); #1;
    st_prev = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c == rst_c) begin
        rst = 1'b1;
        set_start(s, 1'b0);
        @(posedge clk); #1;
        chk_zero(s, "midrst");
        rst = 1'b0;
        prev_res[s] = 0;
        @(posedge clk); #1;
        chk("postrst_busy", o_busy(s), 0);
        chk("postrst_se",   o_se(s),   0);
        return;
      end
      chk("se",    o_se(s),   32'(c <= sc));
      chk("busy",  o_busy(s), 1);
      chk("ovr",   o_ovr(s),  32'(st_prev));
      chk("dv",    o_dv(s),   32'(c == lat));
      if (c <= sc)          chk("dac_smp", o_dac(s), 0);
      else if (c <= cv_end) chk("dac_trial", o_dac(s), exp_dac(vin, n, (c - sc - 1) / cp));
      else                  chk("dac_done", o_dac(s), vin);
      chk("dout", o_do(s), (c == lat) ? vin : prev_res[s]);

      sv = hold || (c == ovr_c);
      set_start(s, sv);
      st_prev = sv && (c <= cv_end);
      correct = (vin >= int'(o_dac(s)));
      last = (c > sc) && (c <= cv_end) && (((c - sc) % cp) == 0);
      set_cmp(s, last ? correct : 1'($urandom));
      if (c < lat) begin
        @(posedge clk); #1;
      end
    end
    prev_res[s] = vin;
  endtask

  initial begin
    prev_res[0] = 0;
    prev_res[1] = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst = 1'b0;
    idle(0, 2);

    // Single conversion and extremes.
    conv(0, 'hA5, 1'b0, 0, 0);  idle(0, 3);
    conv(0, 'h00, 1'b0, 0, 0);  idle(0, 1);
    conv(0, 'hFF, 1'b0, 0, 0);  idle(0, 1);

    // Continuous mode: start never drops between the two conversions.
    conv(0, 'h10, 1'b1, 0, 0);
    conv(0, 'h3C, 1'b0, 0, 0);  idle(0, 2);

    // Overrun during bit 5 (third trial): conversion unaffected, no follow-on.
    conv(0, $urandom_range(0, 255), 1'b0, scy(0) + 3, 0);
    idle(0, 4);

    // Reset during bit 3, then a fresh conversion.
    conv(0, $urandom_range(0, 255), 1'b0, 0, scy(0) + 5);
    conv(0, $urandom_range(0, 255), 1'b0, 0, 0);
    idle(0, 1);

    for (int r = 0; r < 6; r++) begin
      conv(0, $urandom_range(0, 255), r[0], 0, 0);
    end
    idle(0, 2);

    // Second parameter set: 4b, 3 sample cycles, 2 cycles/bit.
    conv(1, 'h9, 1'b0, 0, 0);   idle(1, 2);
    conv(1, 'h0, 1'b0, 0, 0);
    conv(1, 'hF, 1'b0, 0, 0);   idle(1, 1);
    for (int r = 0; r < 4; r++) begin
      conv(1, $urandom_range(0, 15), r[0], 0, 0);
    end
    idle(1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
